// File: rtl/du_host_link.sv
// Host-side sequencer for the debug-unit UART protocol: downloads a program,
// then collects and reassembles the 32-bit debug dump returned after halt.
module du_host_link #(
    parameter int NB_DATA        = 32,
    parameter int ADDRWIDTH      = 7,
    parameter int NUM_DUMP_WORDS = 162,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [7:0]           i_num_instr,
    input  logic [7:0]           i_mode,
    output logic [ADDRWIDTH-1:0] o_prog_addr,
    input  logic [NB_DATA-1:0]   i_prog_data,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done_tick,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_done_tick,
    output logic [NB_DATA-1:0]   o_dump_word,
    output logic                 o_dump_valid,
    output logic [7:0]           o_dump_index,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] LAST_WORD = 8'(NUM_DUMP_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_CNT, SEND_INSTR, SEND_MODE, TX_WAIT, RECV, DONE, ERR
    } state_t;

    typedef enum logic [1:0] {K_CNT, K_INSTR, K_MODE} kind_t;

    state_t                state, state_n;
    kind_t                 kind, kind_n;
    logic [7:0]            num, num_n;
    logic [7:0]            mode, mode_n;
    logic [7:0]            instr_cnt, instr_n;
    logic [1:0]            byte_sel, sel_n;
    logic [ADDRWIDTH-1:0]  prog_addr, addr_n;
    logic [7:0]            tx_data, tx_data_n;
    logic                  tx_start, tx_start_n;
    logic [NB_DATA-1:0]    shift, shift_n;
    logic [1:0]            rx_cnt, rx_cnt_n;
    logic [7:0]            word_idx, widx_n;
    logic [TW-1:0]         timer, timer_n;
    logic [NB_DATA-1:0]    dump_word, dword_n;
    logic                  dump_valid, dvalid_n;
    logic [7:0]            dump_index, dindex_n;
    logic                  busy, busy_n;
    logic                  done, done_n;
    logic                  error, error_n;
    logic [7:0]            instr_byte;

    always_comb begin
        instr_byte = i_prog_data[7:0];
        unique case (byte_sel)
            2'd0:    instr_byte = i_prog_data[NB_DATA-1 -: 8];
            2'd1:    instr_byte = i_prog_data[NB_DATA-9 -: 8];
            2'd2:    instr_byte = i_prog_data[NB_DATA-17 -: 8];
            default: instr_byte = i_prog_data[7:0];
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            kind       <= K_CNT;
            num        <= '0;
            mode       <= '0;
            instr_cnt  <= '0;
            byte_sel   <= '0;
            prog_addr  <= '0;
            tx_data    <= '0;
            tx_start   <= 1'b0;
            shift      <= '0;
            rx_cnt     <= '0;
            word_idx   <= '0;
            timer      <= '0;
            dump_word  <= '0;
            dump_valid <= 1'b0;
            dump_index <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            kind       <= kind_n;
            num        <= num_n;
            mode       <= mode_n;
            instr_cnt  <= instr_n;
            byte_sel   <= sel_n;
            prog_addr  <= addr_n;
            tx_data    <= tx_data_n;
            tx_start   <= tx_start_n;
            shift      <= shift_n;
            rx_cnt     <= rx_cnt_n;
            word_idx   <= widx_n;
            timer      <= timer_n;
            dump_word  <= dword_n;
            dump_valid <= dvalid_n;
            dump_index <= dindex_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        kind_n     = kind;
        num_n      = num;
        mode_n     = mode;
        instr_n    = instr_cnt;
        sel_n      = byte_sel;
        addr_n     = prog_addr;
        tx_data_n  = tx_data;
        tx_start_n = 1'b0;
        shift_n    = shift;
        rx_cnt_n   = rx_cnt;
        widx_n     = word_idx;
        timer_n    = timer;
        dword_n    = dump_word;
        dvalid_n   = 1'b0;
        dindex_n   = dump_index;
        busy_n     = busy;
        done_n     = done;
        error_n    = error;

        unique case (state)
            IDLE, DONE, ERR: begin
                // done/busy settle one cycle after the final strobe
                if (state == DONE) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end
                if (i_start) begin
                    num_n   = i_num_instr;
                    mode_n  = i_mode;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    addr_n  = '0;
                    instr_n = '0;
                    sel_n   = '0;
                    busy_n  = 1'b1;
                    state_n = SEND_CNT;
                end
            end
            SEND_CNT: begin
                tx_data_n  = num;
                tx_start_n = 1'b1;
                kind_n     = K_CNT;
                state_n    = TX_WAIT;
            end
            SEND_INSTR: begin
                tx_data_n  = instr_byte;
                tx_start_n = 1'b1;
                kind_n     = K_INSTR;
                state_n    = TX_WAIT;
            end
            SEND_MODE: begin
                tx_data_n  = mode;
                tx_start_n = 1'b1;
                kind_n     = K_MODE;
                state_n    = TX_WAIT;
            end
            TX_WAIT: begin
                // a tick coincident with our own start belongs to the old byte
                if (i_tx_done_tick && !tx_start) begin
                    unique case (kind)
                        K_CNT: begin
                            state_n = (num == 8'd0) ? SEND_MODE : SEND_INSTR;
                        end
                        K_INSTR: begin
                            if (byte_sel == 2'd3) begin
                                sel_n   = '0;
                                addr_n  = prog_addr + 1'b1;
                                instr_n = instr_cnt + 8'd1;
                                state_n = (instr_n == num) ? SEND_MODE
                                                           : SEND_INSTR;
                            end else begin
                                sel_n   = byte_sel + 2'd1;
                                state_n = SEND_INSTR;
                            end
                        end
                        default: begin
                            rx_cnt_n = '0;
                            widx_n   = '0;
                            timer_n  = '0;
                            shift_n  = '0;
                            state_n  = RECV;
                        end
                    endcase
                end
            end
            RECV: begin
                if (i_rx_done_tick) begin
                    shift_n  = {shift[NB_DATA-9:0], i_rx_data};
                    timer_n  = '0;
                    rx_cnt_n = rx_cnt + 2'd1;
                    if (rx_cnt == 2'd3) begin
                        dword_n  = shift_n;
                        dvalid_n = 1'b1;
                        dindex_n = word_idx;
                        widx_n   = word_idx + 8'd1;
                        if (word_idx == LAST_WORD) begin
                            state_n = DONE;
                        end
                    end
                end else if (timer == TMO_LAST) begin
                    rx_cnt_n = '0;
                    shift_n  = '0;
                    error_n  = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = ERR;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_prog_addr  = prog_addr;
    assign o_tx_data    = tx_data;
    assign o_tx_start   = tx_start;
    assign o_dump_word  = dump_word;
    assign o_dump_valid = dump_valid;
    assign o_dump_index = dump_index;
    assign o_busy       = busy;
    assign o_done       = done;
    assign o_error      = error;

endmodule

// File: tb/tb_du_host_link.sv
// Scoreboard bench for du_host_link: expected tx bytes and dump words are
// queued by the stimulus thread and popped by a monitor on each DUT strobe.
module tb_du_host_link;

    typedef struct packed {
        logic [7:0] d;
        logic [6:0] a;
    } tx_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] w;
    } dump_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_main = 1'b0;
    logic        start_noise = 1'b0;
    logic [7:0]  num_instr = 8'd0;
    logic [7:0]  mode = 8'd0;
    logic [6:0]  prog_addr;
    logic [31:0] prog_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_tick = 1'b0;
    logic        rx_main = 1'b0;
    logic        rx_noise = 1'b0;
    logic [7:0]  rx_data_main = 8'd0;
    logic [7:0]  rx_data_noise = 8'd0;
    logic [31:0] dump_word;
    logic        dump_valid;
    logic [7:0]  dump_index;
    logic        busy;
    logic        done;
    logic        error;

    logic [31:0] prog [128];
    logic [31:0] dir_words [3];
    tx_t         txq [$];
    dump_t       dq [$];
    int          total = 0;
    int          bad = 0;
    int          tx_seen = 0;
    bit          noise = 1'b0;

    assign prog_data = prog[prog_addr];

    du_host_link #(
        .NB_DATA(32),
        .ADDRWIDTH(7),
        .NUM_DUMP_WORDS(3),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_start(start_main | start_noise),
        .i_num_instr(num_instr),
        .i_mode(mode),
        .o_prog_addr(prog_addr),
        .i_prog_data(prog_data),
        .o_tx_data(tx_data),
        .o_tx_start(tx_start),
        .i_tx_done_tick(tx_tick),
        .i_rx_data(rx_main ? rx_data_main : rx_data_noise),
        .i_rx_done_tick(rx_main | rx_noise),
        .o_dump_word(dump_word),
        .o_dump_valid(dump_valid),
        .o_dump_index(dump_index),
        .o_busy(busy),
        .o_done(done),
        .o_error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // monitor: pops expectations whenever the DUT strobes
    initial forever begin
        tx_t   te;
        dump_t de;
        @(negedge clk);
        if (!rst && tx_start) begin
            tx_seen++;
            if (txq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got byte %h", tx_data);
            end else begin
                te = txq.pop_front();
                chk("tx_data", {24'd0, tx_data}, {24'd0, te.d});
                chk("tx_prog_addr", {25'd0, prog_addr}, {25'd0, te.a});
            end
        end
        if (!rst && dump_valid) begin
            if (dq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dump_unexpected: got %h", dump_word);
            end else begin
                de = dq.pop_front();
                chk("dump_index", {24'd0, dump_index}, {24'd0, de.idx});
                chk("dump_word", dump_word, de.w);
            end
        end
    end

    // UART transmitter stand-in: random latency done tick per start
    initial forever begin
        int d;
        @(negedge clk);
        if (!rst && tx_start) begin
            d = $urandom_range(0, 4);
            @(posedge clk);
            repeat (d) @(posedge clk);
            #1 tx_tick = 1'b1;
            @(posedge clk);
            #1 tx_tick = 1'b0;
        end
    end

    // stray start pulses and rx ticks while a download is in flight
    initial forever begin
        @(posedge clk);
        #1;
        start_noise = noise && ($urandom_range(0, 3) == 0);
        rx_noise = noise && ($urandom_range(0, 2) == 0);
        rx_data_noise = 8'($urandom);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_session(input int n, input logic [7:0] md);
        tx_t t;
        t.d = 8'(n);
        t.a = 7'd0;
        txq.push_back(t);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                t.d = prog[i][31-8*b -: 8];
                t.a = 7'(i);
                txq.push_back(t);
            end
        end
        t.d = md;
        t.a = 7'(n);
        txq.push_back(t);
        @(posedge clk);
        #1;
        num_instr = 8'(n);
        mode = md;
        start_main = 1'b1;
        @(posedge clk);
        #1;
        start_main = 1'b0;
        num_instr = 8'($urandom);
        mode = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("first_tx_start", {31'd0, tx_start}, 32'd1);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("error_cleared", {31'd0, error}, 32'd0);
    endtask

    task automatic finish_send();
        int b = 0;
        while (txq.size() != 0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        noise = 1'b0;
        chk("tx_drained", txq.size(), 32'd0);
        b = 0;
        while (!tx_tick && b < 20) begin
            @(negedge clk);
            b++;
        end
        chk("mode_ack_seen", {31'd0, tx_tick}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] v, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        rx_main = 1'b1;
        rx_data_main = v;
        @(posedge clk);
        #1;
        rx_main = 1'b0;
    endtask

    task automatic feed_words(input bit directed);
        dump_t e;
        logic [31:0] wd;
        for (int w = 0; w < 3; w++) begin
            wd = directed ? dir_words[w] : $urandom;
            e.idx = 8'(w);
            e.w = wd;
            dq.push_back(e);
            for (int b = 0; b < 4; b++)
                rx_byte(wd[31-8*b -: 8], $urandom_range(0, 3));
        end
        @(negedge clk);
        chk("done_after_last_strobe", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("done_next_cycle", {31'd0, done}, 32'd1);
        chk("busy_low_done", {31'd0, busy}, 32'd0);
        chk("dump_drained", dq.size(), 32'd0);
    endtask

    task automatic rand_prog();
        for (int i = 0; i < 128; i++) prog[i] = $urandom;
    endtask

    initial begin
        int cyc;
        int mark;
        rand_prog();
        dir_words[0] = 32'h0000_0003;
        dir_words[1] = 32'h0000_0004;
        dir_words[2] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_dump_word", dump_word, 32'd0);
        chk("rst_done_err", {30'd0, done, error}, 32'd0);
        #1 rst = 1'b0;

        prog[0] = 32'h0203_0405;
        prog[1] = 32'h0607_0809;
        start_session(2, 8'h10);
        finish_send();
        chk("addr_after_prog", {25'd0, prog_addr}, 32'd2);
        feed_words(1'b1);

        start_session(0, 8'h10);
        finish_send();
        chk("addr_zero_count", {25'd0, prog_addr}, 32'd0);
        feed_words(1'b0);

        rand_prog();
        start_session(3, 8'($urandom));
        noise = 1'b1;
        finish_send();
        feed_words(1'b0);

        for (int s = 0; s < 4; s++) begin
            rand_prog();
            start_session($urandom_range(0, 5), 8'($urandom));
            finish_send();
            feed_words(1'b0);
        end

        start_session(1, 8'($urandom));
        finish_send();
        rx_byte(8'hAA, 0);
        rx_byte(8'h55, 1);
        cyc = 0;
        repeat (45) begin
            @(negedge clk);
            cyc++;
        end
        chk("no_early_timeout", {31'd0, error}, 32'd0);
        while (!error && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout_error", {31'd0, error}, 32'd1);
        chk("timeout_busy_low", {31'd0, busy}, 32'd0);
        chk("timeout_in_window", {31'd0, (cyc >= 49 && cyc <= 52)}, 32'd1);
        rand_prog();
        start_session(2, 8'($urandom));
        finish_send();
        feed_words(1'b0);

        rand_prog();
        mark = tx_seen;
        start_session(2, 8'($urandom));
        cyc = 0;
        while (tx_seen < mark + 8 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_instr1_byte3", tx_seen - mark, 32'd8);
        cyc = 0;
        while (!tx_tick && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_prog_addr", {25'd0, prog_addr}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_dump", {dump_index, 23'd0, dump_valid}, 32'd0);
        chk("mid_rst_done_err", {30'd0, done, error}, 32'd0);
        txq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        repeat (12) begin
            @(negedge clk);
            if (tx_start) cyc++;
        end
        chk("no_tx_after_rst", cyc, 32'd0);

        rand_prog();
        start_session(2, 8'($urandom));
        finish_send();
        feed_words(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/du_host_link.md
# du_host_link

Host-side end of the debug-unit UART protocol: a hardware sequencer that plays the role of the PC toward `debug_unit`. It downloads a program (instruction count, instruction bytes, mode byte) through a byte-level UART transmitter, then collects the debug dump returned after halt and reassembles it into 32-bit words. It sits between a program source (ROM/BRAM) and a `UART2`-style byte interface, for self-checking boards and loopback benches without a PC.

## Interface
- `NB_DATA`, 32, instruction/dump word width (fixed 4 bytes per word)
- `ADDRWIDTH`, 7, program-source address width
- `NUM_DUMP_WORDS`, 162, words expected after mode byte (PC, cycles, 32 regs, 128 mem)
- `TIMEOUT_CYCLES`, 1000000, max idle clocks between received dump bytes

- `i_clock`  in  1  system clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_start`  in  1  start one download/collect session (sampled in IDLE only)
- `i_num_instr`  in  8  instruction count to send; captured at start
- `i_mode`  in  8  mode byte sent after program; captured at start
- `o_prog_addr`  out  ADDRWIDTH  program-source word address
- `i_prog_data`  in  NB_DATA  program word at `o_prog_addr` (combinational read)
- `o_tx_data`  out  8  byte to UART transmitter
- `o_tx_start`  out  1  one-cycle transmit request
- `i_tx_done_tick`  in  1  transmitter finished current byte
- `i_rx_data`  in  8  received byte
- `i_rx_done_tick`  in  1  `i_rx_data` valid this cycle
- `o_dump_word`  out  NB_DATA  reassembled dump word
- `o_dump_valid`  out  1  one-cycle strobe for `o_dump_word`
- `o_dump_index`  out  8  index of current dump word, 0-based
- `o_busy`  out  1  session in progress
- `o_done`  out  1  session completed; held until next accepted start
- `o_error`  out  1  rx timeout; held until next accepted start

## Operation
- States: IDLE, SEND_CNT, SEND_INSTR, SEND_MODE, TX_WAIT, RECV, DONE, ERR.
- IDLE: on `i_start`, capture count/mode, clear `o_done`/`o_error`, `o_prog_addr`=0, go to SEND_CNT.
- Every send state drives `o_tx_data` and pulses `o_tx_start` for exactly one cycle, then enters TX_WAIT. `o_tx_data` stays stable until `i_tx_done_tick`. The next `o_tx_start` is issued no earlier than one cycle after the tick.
- Byte order is decided: count byte, then for each instruction bytes [31:24], [23:16], [15:8], [7:0], then mode byte.
- `o_prog_addr` increments after the 4th byte of each word has completed.
- `i_num_instr`=0: SEND_CNT goes directly to SEND_MODE after the count byte.
- After the mode byte's done tick, enter RECV with byte counter 0, word index 0, and timeout counter 0.
- RECV: each `i_rx_done_tick` shifts the byte in MSB-first and resets the timeout counter. On the 4th byte, load `o_dump_word` and `o_dump_index` and pulse `o_dump_valid`.
- After word `NUM_DUMP_WORDS-1` is emitted, go to DONE: `o_done`=1, `o_busy`=0, return to IDLE-equivalent acceptance of `i_start`.
- Timeout: counter reaching `TIMEOUT_CYCLES` in RECV goes to ERR: `o_error`=1, `o_busy`=0. A new `i_start` is accepted from ERR.
- `i_rx_done_tick` outside RECV is ignored.
- `i_start` while `o_busy` is ignored.
- Partial bytes in the assembler are discarded on timeout or reset.

## Timing
- Reset, asynchronous: state IDLE; all outputs 0, including `o_tx_data`, `o_prog_addr`, `o_dump_word`, and `o_dump_index`. Reset mid-transfer aborts with no further `o_tx_start`.
- `i_start` at edge N: `o_busy`=1 and `o_tx_start`=1 with the count byte after edge N+1.
- Dump strobe appears the cycle after the 4th byte's `i_rx_done_tick`.
- `o_done` rises the cycle after the last `o_dump_valid`.
- `i_tx_done_tick` arriving in the same cycle as `o_tx_start` is not accepted as completion of the new byte.

## Test plan
- Count 2, program {0x02030405, 0x06070809}, mode 0x10 -> tx bytes 02,02,03,04,05,06,07,08,09,10 in order, one start per done tick, `o_prog_addr` 0→1→2.
- Count 0, mode 0x10 -> tx bytes 00,10 only; `o_prog_addr` stays 0.
- After mode, feed `NUM_DUMP_WORDS`=3 override with rx bytes 00,00,00,03, 00,00,00,04, DE,AD,BE,EF -> strobes with (0,0x00000003), (1,0x00000004), (2,0xDEADBEEF), then `o_done`=1.
- `TIMEOUT_CYCLES`=50, feed 2 rx bytes then silence -> `o_error`=1 at 50 idle cycles, no strobe; new `i_start` clears it.
- `i_start` pulsed mid-instruction send, plus stray `i_rx_done_tick` during send -> byte sequence unchanged, no strobe.
- Assert `i_reset` between bytes 3 and 4 of instruction 1 -> all outputs 0 immediately; next `i_start` restarts from the count byte.
